bowling_roll_entry: RTL and testbench

- Upstream front-end for the bowling score core.
- Turns the raw player push-button and 4-bit pin-count switches into a debounced, validated roll: a stable pin value plus a clean roll strobe.
- Tracks frame number, roll-in-frame and pins standing so that illegal counts never reach the scorer.
- Detects end of game, including 10th-frame bonus rolls.

---
 rtl/bowling_roll_entry_if.sv | 51 +++++
 rtl/bowling_roll_entry.sv | 225 ++++++++++++++++++++++
 tb/tb_bowling_roll_entry.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bowling_roll_entry_if.sv
// ---------------------------------------------------------------------------
// bowling_roll_entry_if
//   Bundles the player-facing inputs and scorer-facing outputs of the roll
//   entry front-end.
//
//   master (player / test side)  : drives rawButton, switchIn; reads results
//   slave  (bowling_roll_entry)  : reads rawButton, switchIn; drives results
//
//   Signals:
//     rawButton   raw push-button, high = pressed (asynchronous, bouncy)
//     switchIn    raw 4-bit pin-count switches
//     pointOut    last accepted pin count, held stable
//     rollStrobe  one pulse per accepted roll
//     frameNum    current frame 1..10
//     rollInFrame roll index 0..2 within the frame
//     pinsLeft    pins standing before the next roll
//     errorFlag   last press was rejected
//     gameOver    game complete
//     fsm_state   debug view of the control FSM (0 IDLE, 1 STROBE, 2 OVER)
//
//   Handshake: there is no back-pressure. A roll is offered by a debounced
//   button press; it is either accepted (pointOut updates and rollStrobe
//   rises on the same edge, staying high for PULSE_LEN cycles) or rejected
//   (errorFlag rises, nothing else changes). The scorer must capture
//   pointOut on the rising edge of rollStrobe; pointOut is held until the
//   next accepted roll.
// ---------------------------------------------------------------------------
interface bowling_roll_entry_if;
  logic       rawButton;
  logic [3:0] switchIn;
  logic [3:0] pointOut;
  logic       rollStrobe;
  logic [3:0] frameNum;
  logic [1:0] rollInFrame;
  logic [3:0] pinsLeft;
  logic       errorFlag;
  logic       gameOver;
  logic [1:0] fsm_state;

  modport master (
    output rawButton, switchIn,
    input  pointOut, rollStrobe, frameNum, rollInFrame, pinsLeft,
           errorFlag, gameOver, fsm_state
  );

  modport slave (
    input  rawButton, switchIn,
    output pointOut, rollStrobe, frameNum, rollInFrame, pinsLeft,
           errorFlag, gameOver, fsm_state
  );
endinterface

// File: rtl/bowling_roll_entry.sv
// ---------------------------------------------------------------------------
// bowling_roll_entry
//   Front-end for the bowling score core. Synchronizes and debounces the
//   player button, validates the switch pin count against the pins still
//   standing, tracks frame / roll / pins, emits one fixed-length strobe per
//   accepted roll and detects end of game (including 10th-frame bonus rolls).
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    bowling_roll_entry_if.slave (button/switch in, roll info out)
//
//   Parameters:
//     DEBOUNCE_CYCLES  cycles the synchronized button must hold a new level
//     PULSE_LEN        rollStrobe high time per accepted roll
// ---------------------------------------------------------------------------
module bowling_roll_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_LEN       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  bowling_roll_entry_if.slave  bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    OVER   = 2'd2
  } state_t;

  // Synchronizers. The button stages reset to 1 so that a button held
  // through reset looks "pressed" and can never arm the press detector.
  logic          btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [3:0]    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  // Debounce
  logic          db_level_q, db_level_d, db_prev_q, db_prev_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          armed_q, armed_d;
  // Control and game state
  state_t        state_q, state_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [3:0]    point_q, point_d;
  logic          strobe_q, strobe_d;
  logic [3:0]    frame_q, frame_d;
  logic [1:0]    roll_q, roll_d;
  logic [3:0]    pins_q, pins_d;
  logic [3:0]    roll0_q, roll0_d;
  logic          err_q, err_d;
  logic          over_q, over_d;

  // Roll-rule results for the current switch value
  logic [3:0]    nxt_frame, nxt_pins, nxt_roll0, rack_after;
  logic [1:0]    nxt_roll;
  logic          ends_game, press, legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q    <= 1'b1;
      btn_s2_q    <= 1'b1;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      db_level_q  <= 1'b0;
      db_prev_q   <= 1'b0;
      db_cnt_q    <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      point_q     <= 4'd0;
      strobe_q    <= 1'b0;
      frame_q     <= 4'd1;
      roll_q      <= 2'd0;
      pins_q      <= 4'd10;
      roll0_q     <= 4'd0;
      err_q       <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      sw_s1_q     <= sw_s1_d;
      sw_s2_q     <= sw_s2_d;
      db_level_q  <= db_level_d;
      db_prev_q   <= db_prev_d;
      db_cnt_q    <= db_cnt_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      point_q     <= point_d;
      strobe_q    <= strobe_d;
      frame_q     <= frame_d;
      roll_q      <= roll_d;
      pins_q      <= pins_d;
      roll0_q     <= roll0_d;
      err_q       <= err_d;
      over_q      <= over_d;
    end
  end

  // Synchronize and debounce the button
  always_comb begin
    btn_s1_d   = bus.rawButton;
    btn_s2_d   = btn_s1_q;
    sw_s1_d    = bus.switchIn;
    sw_s2_d    = sw_s1_q;
    db_level_d = db_level_q;
    db_prev_d  = db_level_q;
    db_cnt_d   = '0;
    if (btn_s2_q != db_level_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_level_d = ~db_level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    // Arm only once a genuine released level has been seen after reset.
    armed_d = armed_q | (~btn_s2_q & ~db_level_q);
  end

  assign press      = db_level_q & ~db_prev_q & armed_q;
  assign legal      = (sw_s2_q <= pins_q);
  assign rack_after = (sw_s2_q == 4'd10) ? 4'd10 : (4'd10 - sw_s2_q);

  // Frame / roll / pins advance for a legal roll of value sw_s2_q
  always_comb begin
    nxt_frame = frame_q;
    nxt_roll  = roll_q;
    nxt_pins  = pins_q;
    nxt_roll0 = roll0_q;
    ends_game = 1'b0;
    if (frame_q != 4'd10) begin
      if (roll_q == 2'd0 && sw_s2_q != 4'd10) begin
        nxt_roll  = 2'd1;
        nxt_pins  = 4'd10 - sw_s2_q;
        nxt_roll0 = sw_s2_q;
      end else begin
        nxt_frame = frame_q + 4'd1;
        nxt_roll  = 2'd0;
        nxt_pins  = 4'd10;
      end
    end else begin
      case (roll_q)
        2'd0: begin
          nxt_roll0 = sw_s2_q;
          nxt_roll  = 2'd1;
          nxt_pins  = rack_after;
        end
        2'd1: begin
          if (roll0_q == 4'd10) begin
            nxt_roll = 2'd2;
            nxt_pins = rack_after;
          end else if (sw_s2_q == pins_q) begin
            // spare earns the bonus roll on a fresh rack
            nxt_roll = 2'd2;
            nxt_pins = 4'd10;
          end else begin
            ends_game = 1'b1;
          end
        end
        default: ends_game = 1'b1;
      endcase
    end
  end

  // Control FSM
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    point_d     = point_q;
    strobe_d    = strobe_q;
    frame_d     = frame_q;
    roll_d      = roll_q;
    pins_d      = pins_q;
    roll0_d     = roll0_q;
    err_d       = err_q;
    over_d      = over_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          if (legal) begin
            point_d     = sw_s2_q;
            err_d       = 1'b0;
            strobe_d    = 1'b1;
            pulse_cnt_d = '0;
            state_d     = STROBE;
            if (ends_game) begin
              over_d = 1'b1;   // counters freeze at the final roll
            end else begin
              frame_d = nxt_frame;
              roll_d  = nxt_roll;
              pins_d  = nxt_pins;
              roll0_d = nxt_roll0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STROBE: begin
        // presses here are dropped without touching errorFlag
        if (pulse_cnt_q == PW'(PULSE_LEN - 1)) begin
          strobe_d    = 1'b0;
          pulse_cnt_d = '0;
          state_d     = over_q ? OVER : IDLE;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      OVER: strobe_d = 1'b0;
      default: state_d = IDLE;
    endcase
  end

  assign bus.pointOut    = point_q;
  assign bus.rollStrobe  = strobe_q;
  assign bus.frameNum    = frame_q;
  assign bus.rollInFrame = roll_q;
  assign bus.pinsLeft    = pins_q;
  assign bus.errorFlag   = err_q;
  assign bus.gameOver    = over_q;
  assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_bowling_roll_entry.sv
// ---------------------------------------------------------------------------
// tb_bowling_roll_entry
//   Directed bench for bowling_roll_entry with DEBOUNCE_CYCLES=4,
//   PULSE_LEN=3. A small game model predicts frame/roll/pins/error/over and
//   pushes each accepted pin count onto exp_q; a monitor pops it on every
//   rollStrobe rise and checks the pulse width on every fall.
// ---------------------------------------------------------------------------
module tb_bowling_roll_entry;

  localparam int DEB = 4;
  localparam int PL  = 3;

  // clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bowling_roll_entry_if bus ();

  bowling_roll_entry #(
    .DEBOUNCE_CYCLES (DEB),
    .PULSE_LEN       (PL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard
  logic [3:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_strobes = 0;

  // model state
  int m_frame, m_roll, m_pins, m_first, m_strobes;
  bit m_err, m_over;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // monitor: pointOut on strobe rise, pulse width on strobe fall
  bit prev_strobe = 1'b0;
  int plen = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_strobe = 1'b0;
      plen = 0;
    end else begin
      if (bus.rollStrobe && !prev_strobe) begin
        n_strobes++;
        if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
        else check("pointOut", int'(bus.pointOut), int'(exp_q.pop_front()));
        plen = 1;
      end else if (bus.rollStrobe) begin
        plen++;
      end else if (prev_strobe) begin
        check("strobe_len", plen, PL);
      end
      prev_strobe = bus.rollStrobe;
    end
  end

  task automatic model_reset();
    m_frame = 1; m_roll = 0; m_pins = 10; m_first = 0;
    m_err = 1'b0; m_over = 1'b0; m_strobes = 0;
    exp_q.delete();
  endtask

  task automatic model_press(input int v);
    if (m_over) return;
    if (v > m_pins) begin
      m_err = 1'b1;
      return;
    end
    m_err = 1'b0;
    m_strobes++;
    exp_q.push_back(v[3:0]);
    if (m_frame < 10) begin
      if (m_roll == 0 && v != 10) begin
        m_roll = 1; m_pins = 10 - v;
      end else begin
        m_frame++; m_roll = 0; m_pins = 10;
      end
    end else if (m_roll == 0) begin
      m_first = v; m_roll = 1; m_pins = (v == 10) ? 10 : 10 - v;
    end else if (m_roll == 1 && (m_first == 10 || m_first + v == 10)) begin
      m_roll = 2;
      m_pins = (m_first == 10 && v != 10) ? 10 - v : 10;
    end else begin
      m_over = 1'b1;
    end
  endtask

  // drivers
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rawButton = 1'b0;
    bus.switchIn = 4'd0;
    model_reset();
    n_strobes = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic press(input int v);
    model_press(v);
    @(negedge clk);
    bus.switchIn = v[3:0];
    repeat (3) @(negedge clk);
    bus.rawButton = 1'b1;
    repeat (10) @(negedge clk);
    bus.rawButton = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".frameNum"},    int'(bus.frameNum),    m_frame);
    check({tag, ".rollInFrame"}, int'(bus.rollInFrame), m_roll);
    check({tag, ".pinsLeft"},    int'(bus.pinsLeft),    m_pins);
    check({tag, ".errorFlag"},   int'(bus.errorFlag),   int'(m_err));
    check({tag, ".gameOver"},    int'(bus.gameOver),    int'(m_over));
    check({tag, ".strobes"},     n_strobes,             m_strobes);
  endtask

  initial begin
    reset = 1'b1;
    bus.rawButton = 1'b0;
    bus.switchIn = 4'd0;

    // reset state
    do_reset();
    check("rst.pointOut",   int'(bus.pointOut),   0);
    check("rst.rollStrobe", int'(bus.rollStrobe), 0);
    check_state("rst");

    // single strike in frame 1
    press(10);
    check_state("strike");
    check("strike.pointOut", int'(bus.pointOut), 10);

    // 7 then illegal 5 then 3
    do_reset();
    press(7);
    press(5);
    check_state("illegal5");
    check("illegal5.pointOut", int'(bus.pointOut), 7);
    press(3);
    check_state("spare3");

    // out-of-range value, then a bouncing button
    do_reset();
    press(12);
    check_state("sw12");
    for (int i = 0; i < 20; i++) begin
      bus.rawButton = ~bus.rawButton;
      repeat (2) @(negedge clk);
    end
    bus.rawButton = 1'b0;
    repeat (12) @(negedge clk);
    check_state("bounce");

    // perfect game plus an ignored 13th press
    do_reset();
    for (int i = 0; i < 12; i++) press(10);
    check_state("perfect");
    check("perfect.fsm_state", int'(bus.fsm_state), 2);
    press(10);
    check_state("after_over");

    // 18 zeros, then spare with bonus 3,7,5
    do_reset();
    for (int i = 0; i < 18; i++) press(0);
    check_state("zeros18");
    press(3);
    press(7);
    check_state("tenth_spare");
    press(5);
    check_state("tenth_bonus");

    // 18 zeros, then open 10th 3,4
    do_reset();
    for (int i = 0; i < 18; i++) press(0);
    press(3);
    press(4);
    check_state("tenth_open");

    // reset during the 2nd strobe cycle, button held through reset
    do_reset();
    model_press(6);
    @(negedge clk);
    bus.switchIn = 4'd6;
    repeat (3) @(negedge clk);
    bus.rawButton = 1'b1;
    for (int i = 0; i < 40 && !bus.rollStrobe; i++) @(negedge clk);
    check("midrst.strobe_seen", int'(bus.rollStrobe), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst.rollStrobe", int'(bus.rollStrobe), 0);
    check("midrst.frameNum",   int'(bus.frameNum),   1);
    check("midrst.pinsLeft",   int'(bus.pinsLeft),   10);
    check("midrst.pointOut",   int'(bus.pointOut),   0);
    model_reset();
    n_strobes = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check_state("held_through_reset");
    bus.rawButton = 1'b0;
    repeat (12) @(negedge clk);
    press(4);
    check_state("after_release");

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
